// File: rtl/four_phase_pkg.sv
// Shared types and constants for the four-phase handshake receiver.
package four_phase_pkg;

    typedef enum logic [1:0] {RESYNC, IDLE, WAIT_LOW} rx_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/four_phase_receiver_fifo.sv
// handshake_fifo: synchronous first-word-fall-through FIFO; head word reads as 0 when empty.
module handshake_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [N-1:0]             push_data,
    input  logic                     pop,
    output logic [N-1:0]             data_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   level_q, level_d;
    logic          push_ok, pop_ok;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_FULL);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + PTR_ONE;
            if (pop_ok)  rd_q <= rd_q + PTR_ONE;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the level counter alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem_q[wr_q] <= push_data;
    end

    assign data_out = empty ? '0 : mem_q[rd_q];
    assign level    = level_q;

endmodule

// File: rtl/four_phase_receiver.sv
// Receive end of a bundled-data four-phase req/ack handshake feeding a valid/ready stream.
// Optional parity check on the bundled data is enabled by defining FOUR_PHASE_PARITY_EN.
module four_phase_receiver
    import four_phase_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_in,
    input  logic [N-1:0]             data_in,
    output logic                     ack_out,
    output logic                     valid_out,
    output logic [N-1:0]             data_out,
    input  logic                     ready_in,
    output logic [$clog2(DEPTH):0]   level
`ifdef FOUR_PHASE_PARITY_EN
    ,
    input  logic                     parity_in,
    output logic                     parity_err
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    rx_state_t              state_q, state_d;
    logic                   ack_q, ack_d;
    logic                   capture, parity_ok, push;
    logic                   fifo_empty, fifo_full;

    // Flops reset high so a request already in flight is never mistaken for a fresh one.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESYNC;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESYNC:   if (!req_s)             state_d = IDLE;
            IDLE:     if (req_s && !fifo_full) state_d = WAIT_LOW;
            WAIT_LOW: if (!req_s)             state_d = IDLE;
            default:                          state_d = RESYNC;
        endcase
    end

    always_comb begin
        capture = (state_q == IDLE) && req_s && !fifo_full;
        ack_d   = (state_d == WAIT_LOW);
        push    = capture && parity_ok;
    end

`ifdef FOUR_PHASE_PARITY_EN
    logic parity_err_q;

    assign parity_ok = ~(^{data_in, parity_in});

    always_ff @(posedge clk) begin
        if (reset)                      parity_err_q <= 1'b0;
        else if (capture && !parity_ok) parity_err_q <= 1'b1;
    end
    assign parity_err = parity_err_q;
`else
    assign parity_ok = 1'b1;
`endif

    handshake_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data_in),
        .pop       (ready_in),
        .data_out  (data_out),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign ack_out   = ack_q;
    assign valid_out = ~fifo_empty;

endmodule

// File: tb/tb_four_phase_receiver.sv
// Bench for four_phase_receiver: directed scenarios plus randomized transfers against a queue model.
module tb_four_phase_receiver;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   req_in = 1'b0;
    logic                   ready_in = 1'b0;
    logic [N-1:0]           data_in = '0;
    logic                   ack_out, valid_out;
    logic [N-1:0]           data_out;
    logic [$clog2(DEPTH):0] level;
`ifdef FOUR_PHASE_PARITY_EN
    logic                   parity_in = 1'b0;
    logic                   parity_err;
    bit                     par_flip = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit done  = 1'b0;

    always #5 clk = ~clk;

    four_phase_receiver #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_in    (req_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .level     (level)
`ifdef FOUR_PHASE_PARITY_EN
        ,
        .parity_in (parity_in),
        .parity_err(parity_err)
`endif
    );

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Protocol-level model: req seen two edges late, a queue for the FIFO,
    // and flags for "seen req low since reset" and "ack raised".
    logic [N-1:0] mq[$];
    bit m_ack = 0, m_armed = 0, m_perr = 0, s1 = 1, s2 = 1, started = 0;

    always @(posedge clk) begin
        bit req_s, par_ok;
        int sz;
        req_s = s2;
        sz    = mq.size();
        if (reset) begin
            s1 = 1; s2 = 1; m_ack = 0; m_armed = 0; m_perr = 0;
            mq.delete();
            started = 1;
        end else begin
            par_ok = 1;
`ifdef FOUR_PHASE_PARITY_EN
            par_ok = ((^data_in) ^ parity_in) == 1'b0;
`endif
            if (ready_in && sz > 0) void'(mq.pop_front());
            if (!m_armed) begin
                if (!req_s) m_armed = 1;
            end else if (m_ack) begin
                if (!req_s) m_ack = 0;
            end else if (req_s && sz < DEPTH) begin
                m_ack = 1;
                if (par_ok) mq.push_back(data_in);
                else        m_perr = 1;
            end
            s2 = s1;
            s1 = req_in;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_ack",   int'(ack_out),   int'(m_ack));
            chk("m_valid", int'(valid_out), int'(mq.size() > 0));
            chk("m_level", int'(level),     mq.size());
            chk("m_data",  int'(data_out),  (mq.size() > 0) ? int'(mq[0]) : 0);
`ifdef FOUR_PHASE_PARITY_EN
            chk("m_perr",  int'(parity_err), int'(m_perr));
`endif
        end
    end

    task automatic wait_ack(bit lvl, string nm);
        int n = 0;
        while (ack_out !== lvl && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (ack_out !== lvl) begin
            bad++;
            $display("FAIL %s: ack_out=%0b expected %0b within 64 cycles", nm, ack_out, lvl);
        end
    endtask

    task automatic send(logic [N-1:0] d, int hold);
        data_in = d;
`ifdef FOUR_PHASE_PARITY_EN
        parity_in = (^d) ^ par_flip;
`endif
        req_in = 1'b1;
        @(negedge clk);
        wait_ack(1'b1, "ack_rise");
        repeat (hold) @(negedge clk);
        req_in = 1'b0;
        data_in = N'($urandom);
        @(negedge clk);
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic pop1();
        ready_in = 1'b1;
        @(negedge clk);
        ready_in = 1'b0;
    endtask

    initial begin
        logic [N-1:0] exp2 [4];
        exp2[0] = 8'h02; exp2[1] = 8'h03; exp2[2] = 8'h04; exp2[3] = 8'h05;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", int'(ack_out), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_level", int'(level), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // single transfer, 3-edge latency each way
        data_in = 8'hAA;
`ifdef FOUR_PHASE_PARITY_EN
        parity_in = ^data_in;
`endif
        req_in = 1'b1;
        @(negedge clk); chk("t1_rise_e1", int'(ack_out), 0);
        @(negedge clk); chk("t1_rise_e2", int'(ack_out), 0);
        @(negedge clk); chk("t1_rise_e3", int'(ack_out), 1);
        chk("t1_valid", int'(valid_out), 1);
        chk("t1_data", int'(data_out), 8'hAA);
        req_in = 1'b0;
        @(negedge clk); chk("t1_fall_e1", int'(ack_out), 1);
        @(negedge clk); chk("t1_fall_e2", int'(ack_out), 1);
        @(negedge clk); chk("t1_fall_e3", int'(ack_out), 0);
        pop1();
        chk("t1_level", int'(level), 0);

        // burst to full, stalled fifth request
        for (int i = 1; i <= 4; i++) send(N'(i), 0);
        chk("t2_full", int'(level), 4);
        data_in = 8'h05;
`ifdef FOUR_PHASE_PARITY_EN
        parity_in = ^data_in;
`endif
        req_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("t2_stall_ack", int'(ack_out), 0);
        chk("t2_stall_level", int'(level), 4);
        pop1();
        chk("t2_after_pop", int'(level), 3);
        wait_ack(1'b1, "t2_ack5");
        req_in = 1'b0;
        @(negedge clk);
        wait_ack(1'b0, "t2_ack5_fall");
        chk("t2_level4", int'(level), 4);
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", int'(data_out), int'(exp2[i]));
            @(negedge clk);
        end
        ready_in = 1'b0;
        chk("t2_drained", int'(level), 0);

        // simultaneous push and pop
        send(8'h10, 0);
        chk("t3_head", int'(data_out), 8'h10);
        data_in = 8'h11;
`ifdef FOUR_PHASE_PARITY_EN
        parity_in = ^data_in;
`endif
        req_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ready_in = 1'b1;
        @(negedge clk);
        chk("t3_level", int'(level), 1);
        chk("t3_data", int'(data_out), 8'h11);
        chk("t3_ack", int'(ack_out), 1);
        ready_in = 1'b0;
        req_in = 1'b0;
        @(negedge clk);
        wait_ack(1'b0, "t3_fall");
        pop1();
        chk("t3_empty", int'(level), 0);

        // reset in the middle of a handshake
        data_in = 8'h77;
`ifdef FOUR_PHASE_PARITY_EN
        parity_in = ^data_in;
`endif
        req_in = 1'b1;
        @(negedge clk);
        wait_ack(1'b1, "t4_rise");
        reset = 1'b1;
        @(negedge clk);
        chk("t4_rst_ack", int'(ack_out), 0);
        chk("t4_rst_level", int'(level), 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_no_ack", int'(ack_out), 0);
        chk("t4_no_cap", int'(level), 0);
        req_in = 1'b0;
        repeat (4) @(negedge clk);
        send(8'h5C, 0);
        chk("t4_new", int'(data_out), 8'h5C);
        pop1();

        // pointer wrap
        for (int i = 0; i < 10; i++) begin
            send(N'(8'h20 + i), 0);
            chk("t5_data", int'(data_out), 8'h20 + i);
            chk("t5_level", int'(level), 1);
            pop1();
        end
        chk("t5_empty", int'(level), 0);

`ifdef FOUR_PHASE_PARITY_EN
        // parity error: acked, dropped, sticky flag
        par_flip = 1'b1;
        send(8'h03, 0);
        chk("t6_dropped", int'(level), 0);
        chk("t6_err", int'(parity_err), 1);
        par_flip = 1'b0;
        send(8'h03, 0);
        chk("t6_pushed", int'(level), 1);
        chk("t6_data", int'(data_out), 8'h03);
        chk("t6_sticky", int'(parity_err), 1);
        pop1();
`endif

        // randomized transfers with random downstream backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef FOUR_PHASE_PARITY_EN
                    par_flip = ($urandom_range(0, 7) == 0);
`endif
                    send(N'($urandom), $urandom_range(0, 3));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready_in = ($urandom_range(0, 2) == 0);
                    @(negedge clk);
                end
            end
        join
        ready_in = 1'b1;
        repeat (8) @(negedge clk);
        ready_in = 1'b0;
        chk("rand_drained", int'(level), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
